// File: rtl/uart_rx.sv
// uart_rx -- asynchronous serial receiver with a hold-until-acknowledged
// output register.
//
// Frame: idle high, start bit (0), 8 data bits MSB first, stop bit (1),
// CLKS_PER_BIT clocks per bit. The line is double-flopped before use and
// sampled at mid-bit, which gives the receiver margin against a few percent
// of baud mismatch.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit, legal range 4..255
//
// Ports
//   in_clk       system clock, rising edge
//   in_rst       synchronous active-high reset
//   in_rx        asynchronous serial line, idle high
//   in_rd_ack    consumer acknowledge, clears out_valid
//   out_data     last good received byte (MSB = first data bit on the line)
//   out_valid    out_data holds an unread byte (level)
//   out_busy     receiver is not idle (registered)
//   out_frm_err  one-cycle pulse: stop bit sampled low
//   out_ovr      one-cycle pulse: unread byte overwritten by a new one
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 235
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_rx,
  input  logic       in_rd_ack,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_busy,
  output logic       out_frm_err,
  output logic       out_ovr
);

  // Terminal counts for the bit timer. The start bit is sampled half a bit
  // in, every later bit one full bit after that, so all samples land mid-bit.
  localparam logic [7:0] HALF_M1 = 8'((CLKS_PER_BIT / 2) - 1);
  localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  // Synchroniser flops; both idle high so reset never looks like a start bit.
  logic       rx_meta_r;
  logic       rx_sync_r;
  logic       rx_s;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] timer_r;
  logic [7:0] timer_s;
  logic [3:0] bit_cnt_r;
  logic [3:0] bit_cnt_s;
  logic [7:0] shift_r;
  logic [7:0] shift_s;

  // One-cycle strobes from the stop-bit decision.
  logic       load_s;
  logic       frm_err_s;

  logic [7:0] data_r;
  logic [7:0] data_s;
  logic       valid_r;
  logic       valid_s;
  logic       busy_r;
  logic       busy_s;
  logic       frm_err_r;
  logic       ovr_r;
  logic       ovr_s;

  assign rx_s = rx_sync_r;

  // Two-flop synchroniser on the raw serial line.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= in_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receiver FSM next-state, bit timer, bit counter and shift register.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r + 8'd1;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    load_s    = 1'b0;
    frm_err_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        timer_s   = 8'd0;
        bit_cnt_s = 4'd0;
        if (!rx_s) begin
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end

      S_START: begin
        if (timer_r == HALF_M1) begin
          timer_s = 8'd0;
          // A line that is high again at mid start bit was only a glitch.
          if (!rx_s) begin
            state_s = S_DATA;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_START;
        end
      end

      S_DATA: begin
        if (timer_r == BIT_M1) begin
          timer_s   = 8'd0;
          // Shift left so the first bit received ends up in the MSB.
          shift_s   = {shift_r[6:0], rx_s};
          bit_cnt_s = bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd7) begin
            state_s = S_STOP;
          end else begin
            state_s = S_DATA;
          end
        end else begin
          state_s = S_DATA;
        end
      end

      S_STOP: begin
        if (timer_r == BIT_M1) begin
          timer_s = 8'd0;
          if (rx_s) begin
            load_s  = 1'b1;
            state_s = S_IDLE;
          end else begin
            // Bad stop bit: drop the byte and wait out any break condition.
            frm_err_s = 1'b1;
            state_s   = S_WAIT_IDLE;
          end
        end else begin
          state_s = S_STOP;
        end
      end

      S_WAIT_IDLE: begin
        timer_s = 8'd0;
        if (rx_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WAIT_IDLE;
        end
      end

      default: begin
        timer_s   = 8'd0;
        bit_cnt_s = 4'd0;
        state_s   = S_IDLE;
      end
    endcase
  end

  // Output holding register: new bytes, acknowledges and overrun detection.
  always_comb begin
    data_s  = data_r;
    valid_s = valid_r;
    ovr_s   = 1'b0;

    if (load_s) begin
      // A new byte always wins; an ack in the same cycle only suppresses
      // the overrun report because the old byte was consumed.
      data_s  = shift_r;
      valid_s = 1'b1;
      ovr_s   = valid_r & ~in_rd_ack;
    end else if (in_rd_ack && valid_r) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    // Busy follows the next state so it drops on the same edge as out_valid.
    if (state_s != S_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_r   <= S_IDLE;
      timer_r   <= 8'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      data_r    <= 8'd0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      frm_err_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      data_r    <= data_s;
      valid_r   <= valid_s;
      busy_r    <= busy_s;
      frm_err_r <= frm_err_s;
      ovr_r     <= ovr_s;
    end
  end

  assign out_data    = data_r;
  assign out_valid   = valid_r;
  assign out_busy    = busy_r;
  assign out_frm_err = frm_err_r;
  assign out_ovr     = ovr_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx.
// The stimulus thread builds serial frames, works out from frame timing
// arithmetic when and how each frame must complete, and queues that
// expectation. A monitor pops one entry each time the DUT shows an event
// (busy falling, valid falling, framing-error pulse) and compares it.
module tb_uart_rx;

  localparam int unsigned CPB  = 235;
  localparam int unsigned HALF = CPB / 2;

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       in_rx;
  logic       in_rd_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_busy;
  logic       out_frm_err;
  logic       out_ovr;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_rx      (in_rx),
    .in_rd_ack  (in_rd_ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_busy   (out_busy),
    .out_frm_err(out_frm_err),
    .out_ovr    (out_ovr)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    string       tag;
    int unsigned cyc;
    logic [7:0]  data;
    logic        valid;
    logic        busy;
    logic        ovr;
    logic        frm;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        mon_en   = 1'b0;
  logic        prev_busy  = 1'b0;
  logic        prev_valid = 1'b0;

  // Reference state of the output register, advanced in stimulus order.
  logic        m_valid = 1'b0;
  logic [7:0]  m_data  = 8'h00;

  // Rising-edge counter; at a falling edge it equals the index of the last rising edge.
  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input int unsigned c, input logic [7:0] d,
                      input logic v, input logic b, input logic o, input logic f);
    exp_t x;
    x.tag = tag; x.cyc = c; x.data = d; x.valid = v; x.busy = b; x.ovr = o; x.frm = f;
    q.push_back(x);
  endtask

  // Monitor: one scoreboard entry per observable DUT event.
  always @(negedge in_clk) begin
    if (mon_en) begin
      if ((prev_busy && !out_busy) || (prev_valid && !out_valid) || out_frm_err) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: busy=%0b valid=%0b frm=%0b at cycle %0d, none queued",
                   out_busy, out_valid, out_frm_err, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.tag, "_cycle"}, cyc, e.cyc);
          chk({e.tag, "_data"},  {24'd0, out_data}, {24'd0, e.data});
          chk({e.tag, "_valid"}, {31'd0, out_valid}, {31'd0, e.valid});
          chk({e.tag, "_busy"},  {31'd0, out_busy}, {31'd0, e.busy});
          chk({e.tag, "_ovr"},   {31'd0, out_ovr}, {31'd0, e.ovr});
          chk({e.tag, "_frm"},   {31'd0, out_frm_err}, {31'd0, e.frm});
        end
      end else if (out_ovr) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_ovr: got 1 expected 0 at cycle %0d", cyc);
      end
      prev_busy  <= out_busy;
      prev_valid <= out_valid;
    end
  end

  // Drive one frame starting at the current falling edge. abort_c >= 0 applies
  // reset that many clocks into the frame and abandons the rest of it.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic ack_col,
                            input int trail_low, input int abort_c);
    logic [9:0]  bits;
    int unsigned k;
    int unsigned e_cyc;
    bits  = {1'b0, b, stop_bit};
    k     = cyc + 1;
    e_cyc = k + 2 + HALF + 9 * CPB;
    if (abort_c < 0) begin
      if (stop_bit) begin
        push("good", e_cyc, b, 1'b1, 1'b0, m_valid && !ack_col, 1'b0);
        m_valid = 1'b1;
        m_data  = b;
      end else begin
        push("frm_err", e_cyc, m_data, m_valid, 1'b1, 1'b0, 1'b1);
        push("frm_end", k + 10 * CPB + trail_low + 2, m_data, m_valid, 1'b0, 1'b0, 1'b0);
      end
    end
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == abort_c) begin
        in_rx  = 1'b1;
        in_rst = 1'b1;
        push("reset", cyc + 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        m_valid = 1'b0;
        m_data  = 8'h00;
        @(negedge in_clk);
        in_rst = 1'b0;
        break;
      end
      in_rx     = bits[9 - (c / CPB)];
      in_rd_ack = ack_col && ((cyc + 1) == e_cyc);
      @(negedge in_clk);
    end
    in_rd_ack = 1'b0;
    repeat (trail_low) @(negedge in_clk);
    in_rx = 1'b1;
  endtask

  task automatic glitch();
    push("glitch", cyc + 1 + 2 + HALF, m_data, m_valid, 1'b0, 1'b0, 1'b0);
    in_rx = 1'b0;
    repeat (50) @(negedge in_clk);
    in_rx = 1'b1;
    repeat (200) @(negedge in_clk);
  endtask

  task automatic ack();
    in_rd_ack = 1'b1;
    if (m_valid) begin
      push("ack", cyc + 1, m_data, 1'b0, 1'b0, 1'b0, 1'b0);
      m_valid = 1'b0;
    end
    @(negedge in_clk);
    in_rd_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  initial begin
    logic [7:0] rb;
    in_rst    = 1'b1;
    in_rx     = 1'b1;
    in_rd_ack = 1'b0;
    repeat (3) @(negedge in_clk);
    chk("rst_data",  {24'd0, out_data}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, out_busy}, 32'd0);
    chk("rst_frm",   {31'd0, out_frm_err}, 32'd0);
    chk("rst_ovr",   {31'd0, out_ovr}, 32'd0);
    in_rst = 1'b0;
    mon_en = 1'b1;
    idle(10);

    // Clean frame, then acknowledge.
    send_frame(8'h2D, 1'b1, 1'b0, 0, -1);
    idle(5);
    ack();
    idle(20);

    // Short low pulse on an idle line.
    glitch();

    // Bad stop bit followed by a held-low line.
    send_frame(8'h15, 1'b0, 1'b0, 500, -1);
    idle(20);

    // Overrun: two back-to-back frames without an acknowledge.
    send_frame(8'h01, 1'b1, 1'b0, 0, -1);
    send_frame(8'h3F, 1'b1, 1'b0, 0, -1);
    idle(5);
    ack();
    idle(10);

    // Acknowledge landing on the completion cycle of the second frame.
    send_frame(8'h05, 1'b1, 1'b0, 0, -1);
    send_frame(8'h33, 1'b1, 1'b1, 0, -1);
    idle(5);
    ack();
    idle(10);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'h1B, 1'b1, 1'b0, 0, int'(HALF + 5 * CPB));
    idle(20);
    send_frame(8'h2A, 1'b1, 1'b0, 0, -1);
    idle(5);
    ack();
    idle(10);

    // Random payloads, gaps, acknowledges and ack collisions.
    for (int i = 0; i < 8; i++) begin
      rb = {2'b00, 6'($urandom)};
      send_frame(rb, 1'b1, 1'($urandom_range(0, 1)), 0, -1);
      if ($urandom_range(0, 1) == 1) ack();
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 30)));
    end
    ack();

    for (int t = 0; t < 5000 && q.size() > 0; t++) @(negedge in_clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected events never seen, first is %s at cycle %0d",
               q.size(), q[0].tag, q[0].cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
